// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the 6502 fetch stage: FSM state encoding and
// the instruction-size normalisation applied to the decoder's byte count.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    S_REQ_OP = 3'd0,
    S_LAT_OP = 3'd1,
    S_DEC    = 3'd2,
    S_LAT_B1 = 3'd3,
    S_LAT_B2 = 3'd4,
    S_VALID  = 3'd5
  } fetch_state_t;

  localparam logic [1:0] SIZE_1 = 2'd1;
  localparam logic [1:0] SIZE_3 = 2'd3;

  // A size of zero comes from unknown opcodes; they run as 1-byte NOPs.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd0) ? SIZE_1 : size;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: reads opcode and 0..2 operand bytes, owns the PC, and hands
// the assembled instruction to execute over a valid/ready handshake.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        dec_opcode,
  input  logic [1:0]        dec_instr_size,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_op_lo,
  output logic [7:0]        instr_op_hi,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_next_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [7:0]        r_opcode;
  logic [7:0]        r_op_lo;
  logic [7:0]        r_op_hi;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [1:0]        w_dec_size;
  logic              w_rd_en;

  assign w_pc_inc   = r_pc + 1'b1;
  assign w_dec_size = norm_size(dec_instr_size);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ_OP;
    end else if (redirect_valid) begin
      r_state <= S_REQ_OP;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_REQ_OP: w_next_state = S_LAT_OP;
      S_LAT_OP: w_next_state = S_DEC;
      S_DEC:    w_next_state = (w_dec_size == SIZE_1) ? S_VALID : S_LAT_B1;
      S_LAT_B1: w_next_state = (r_size == SIZE_3) ? S_LAT_B2 : S_VALID;
      S_LAT_B2: w_next_state = S_VALID;
      S_VALID:  w_next_state = instr_ready ? S_REQ_OP : S_VALID;
      default:  w_next_state = S_REQ_OP;
    endcase
  end

  always_comb begin
    w_rd_en  = 1'b0;
    mem_addr = r_pc;
    unique case (r_state)
      S_REQ_OP: w_rd_en = 1'b1;
      S_DEC:    w_rd_en = (w_dec_size != SIZE_1);
      S_LAT_B1: begin
        if (r_size == SIZE_3) begin
          w_rd_en  = 1'b1;
          mem_addr = w_pc_inc;
        end
      end
      default:  w_rd_en = 1'b0;
    endcase
  end

  // Reset is synchronous, so gate the strobes while it is held to keep
  // memory and execute quiet during the reset cycle itself.
  assign mem_rd_en   = w_rd_en & ~rst;
  assign instr_valid = (r_state == S_VALID) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr_pc <= RESET_PC;
      r_opcode   <= 8'h00;
      r_op_lo    <= 8'h00;
      r_op_hi    <= 8'h00;
      r_size     <= SIZE_1;
    end else if (redirect_valid) begin
      r_pc    <= redirect_pc;
      r_op_lo <= 8'h00;
      r_op_hi <= 8'h00;
    end else begin
      unique case (r_state)
        S_LAT_OP: begin
          r_opcode   <= mem_rdata;
          r_instr_pc <= r_pc;
          r_pc       <= w_pc_inc;
          r_op_lo    <= 8'h00;
          r_op_hi    <= 8'h00;
        end
        S_DEC:    r_size <= w_dec_size;
        S_LAT_B1: begin
          r_op_lo <= mem_rdata;
          r_pc    <= w_pc_inc;
        end
        S_LAT_B2: begin
          r_op_hi <= mem_rdata;
          r_pc    <= w_pc_inc;
        end
        default: ;
      endcase
    end
  end

  // The PC only advances past the last byte, so in S_VALID it is the branch base.
  assign dec_opcode    = r_opcode;
  assign instr_opcode  = r_opcode;
  assign instr_op_lo   = r_op_lo;
  assign instr_op_hi   = r_op_hi;
  assign instr_pc      = r_instr_pc;
  assign instr_next_pc = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: program memory and decoder models,
// a stream-level reference model feeding a scoreboard, and a bundle monitor.
module tb_instr_fetch;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  op_lo;
    logic [7:0]  op_hi;
    logic [15:0] pc;
    logic [15:0] next_pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  dec_opcode;
  logic [1:0]  dec_instr_size;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_op_lo;
  logic [7:0]  instr_op_hi;
  logic [15:0] instr_pc;
  logic [15:0] instr_next_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [7:0]  mem [0:65535];
  bundle_t     sb[$];
  int          total = 0;
  int          bad = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .dec_opcode    (dec_opcode),
    .dec_instr_size(dec_instr_size),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_op_lo   (instr_op_lo),
    .instr_op_hi   (instr_op_hi),
    .instr_pc      (instr_pc),
    .instr_next_pc (instr_next_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  // Synchronous program memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [1:0] dec_size(input logic [7:0] op);
    case (op)
      8'hE8:   return 2'd1;
      8'hA9:   return 2'd2;
      8'h4C:   return 2'd3;
      default: return op[1:0];
    endcase
  endfunction

  assign dec_instr_size = dec_size(dec_opcode);

  function automatic int eff_size(input logic [7:0] op);
    int s;
    s = int'(dec_size(op));
    return (s == 0) ? 1 : s;
  endfunction

  // Reference model: the sequence of bundles execute should see from a start PC.
  task automatic predict(input logic [15:0] start, input int n);
    logic [15:0] pc;
    bundle_t     b;
    int          s;
    pc = start;
    for (int i = 0; i < n; i++) begin
      s         = eff_size(mem[pc]);
      b.opcode  = mem[pc];
      b.pc      = pc;
      b.op_lo   = (s >= 2) ? mem[16'(pc + 16'd1)] : 8'h00;
      b.op_hi   = (s == 3) ? mem[16'(pc + 16'd2)] : 8'h00;
      b.next_pc = 16'(pc + 16'(s));
      sb.push_back(b);
      pc = b.next_pc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented bundle is compared with the scoreboard head;
  // the head is retired only when execute accepts it.
  initial begin
    bundle_t b;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got bundle pc=%0h expected none (t=%0t)", instr_pc, $time);
        end else begin
          b = sb[0];
          check("opcode",  32'(instr_opcode),  32'(b.opcode));
          check("op_lo",   32'(instr_op_lo),   32'(b.op_lo));
          check("op_hi",   32'(instr_op_hi),   32'(b.op_hi));
          check("pc",      32'(instr_pc),      32'(b.pc));
          check("next_pc", 32'(instr_next_pc), 32'(b.next_pc));
          if (instr_ready === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       instr_ready = 1'b1;
        1:       instr_ready = ($urandom_range(0, 3) != 0);
        default: instr_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_from_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic redirect(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    sb.delete();
  endtask

  task automatic wait_valid(output int lat, input int budget);
    lat = 0;
    while (instr_valid !== 1'b1 && lat < budget) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] t1;
    logic [15:0] t2;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_rd_en",  32'(mem_rd_en),     32'd0);
    check("rst_valid",  32'(instr_valid),   32'd0);
    check("rst_addr",   32'(mem_addr),      32'h0000);
    check("rst_ipc",    32'(instr_pc),      32'h0000);
    check("rst_npc",    32'(instr_next_pc), 32'h0000);
    check("rst_opcode", 32'(dec_opcode),    32'h00);
    check("rst_op_lo",  32'(instr_op_lo),   32'h00);
    check("rst_op_hi",  32'(instr_op_hi),   32'h00);

    // 1-byte instruction at reset vector
    mem[16'h0000] = 8'hE8;
    rst = 1'b0;
    #1;
    check("c0_rd_en", 32'(mem_rd_en), 32'd1);
    check("c0_addr",  32'(mem_addr),  32'h0000);
    predict(16'h0000, 1);
    wait_valid(lat, 20);
    check("lat_1byte", 32'(lat), 32'd3);
    wait_empty("drain_1byte", 20);

    // 2-byte instruction: operand read issued in the decode cycle
    mem[16'h0000] = 8'hA9;
    mem[16'h0001] = 8'h42;
    start_from_reset();
    predict(16'h0000, 1);
    step();
    step();
    check("dec_rd_en", 32'(mem_rd_en), 32'd1);
    check("dec_addr",  32'(mem_addr),  32'h0001);
    wait_valid(lat, 20);
    check("lat_2byte", 32'(lat + 2), 32'd4);
    wait_empty("drain_2byte", 20);

    // 3-byte instruction at 0010
    mem[16'h0010] = 8'h4C;
    mem[16'h0011] = 8'h34;
    mem[16'h0012] = 8'h12;
    redirect(16'h0010);
    predict(16'h0010, 1);
    wait_valid(lat, 20);
    check("lat_3byte", 32'(lat), 32'd5);
    wait_empty("drain_3byte", 20);

    // Backpressure: bundle held, no reads; release resumes at next_pc
    mem[16'h0020] = 8'h4C;
    mem[16'h0021] = 8'h78;
    mem[16'h0022] = 8'h56;
    mem[16'h0023] = 8'hA9;
    mem[16'h0024] = 8'h11;
    ready_mode = 2;
    redirect(16'h0020);
    predict(16'h0020, 2);
    wait_valid(lat, 20);
    check("lat_bp", 32'(lat), 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("bp_rd_en", 32'(mem_rd_en), 32'd0);
      step();
    end
    ready_mode = 0;
    step();
    check("ack_rd_en", 32'(mem_rd_en), 32'd1);
    check("ack_addr",  32'(mem_addr),  32'h0023);
    wait_empty("drain_bp", 20);

    // Redirect during operand fetch: partial instruction dropped
    mem[16'h0040] = 8'h4C;
    mem[16'h0041] = 8'h9A;
    mem[16'h0042] = 8'hBC;
    redirect(16'h0040);
    step();
    step();
    step();
    redirect(16'h0200);
    check("rdr_rd_en", 32'(mem_rd_en),   32'd1);
    check("rdr_addr",  32'(mem_addr),    32'h0200);
    check("rdr_valid", 32'(instr_valid), 32'd0);
    ready_mode = 2;
    predict(16'h0200, 1);
    wait_valid(lat, 20);
    check("lat_rdr", 32'(lat), 32'(2 + eff_size(mem[16'h0200])));
    // Redirect coincident with handshake: bundle is consumed
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0300;
    ready_mode     = 0;
    step();
    redirect_valid = 1'b0;
    check("coincident_consumed", 32'(sb.size()), 32'd0);
    sb.delete();
    check("coin_rd_en", 32'(mem_rd_en), 32'd1);
    check("coin_addr",  32'(mem_addr),  32'h0300);
    predict(16'h0300, 4);
    ready_mode = 1;
    wait_empty("drain_coin", 200);

    // PC wrap inside an instruction
    mem[16'hFFFF] = 8'hA9;
    mem[16'h0000] = 8'h5A;
    redirect(16'hFFFF);
    predict(16'hFFFF, 2);
    wait_empty("drain_wrap", 100);

    // Reset during the second operand read
    mem[16'h0100] = 8'h4C;
    ready_mode = 0;
    redirect(16'h0100);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    check("rstmid_valid", 32'(instr_valid), 32'd0);
    check("rstmid_rd_en", 32'(mem_rd_en),   32'd0);
    rst = 1'b0;
    #1;
    check("rstmid_rd_en2", 32'(mem_rd_en), 32'd1);
    check("rstmid_addr",   32'(mem_addr),  32'h0000);
    predict(16'h0000, 3);
    ready_mode = 1;
    wait_empty("drain_rstmid", 200);

    // Random streams, random backpressure, random mid-fetch redirects
    for (int it = 0; it < 12; it++) begin
      t1 = (it % 4 == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
      t2 = (it % 3 == 0) ? 16'($urandom_range(16'hFFFD, 16'hFFFF)) : 16'($urandom);
      redirect(t1);
      predict(t1, 1);
      for (int k = 0, n = $urandom_range(0, 6); k < n; k++) step();
      redirect(t2);
      predict(t2, 6);
      wait_empty("drain_rand", 400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
